// File: rtl/gray_code_converter_pipelined_pkg.sv
// Shared types and width-generic Binary/Gray conversion helpers for the pipelined converter.
// Helpers work on zero-extended MAX_WIDTH words, which gives the correct result for any narrower width.
package gray_code_pkg;

  localparam int unsigned MAX_WIDTH     = 32'd64;
  localparam int unsigned DEFAULT_WIDTH = 32'd8;

  typedef enum logic {
    MODE_BIN2GRAY = 1'b0,
    MODE_GRAY2BIN = 1'b1
  } conv_mode_e;

  typedef struct packed {
    logic                     valid;
    conv_mode_e               mode;
    logic [DEFAULT_WIDTH-1:0] data;
  } pipe_stage_t;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 32'd1);
  endfunction

  // Log-depth prefix XOR: each bit becomes the XOR of itself and every more significant Gray bit
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin = gray;
    for (int unsigned shift = 32'd1; shift < MAX_WIDTH; shift = shift << 32'd1) begin
      bin = bin ^ (bin >> shift);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_code_converter_pipelined_if.sv
// Valid/ready stream bundle of the pipelined Gray converter: input stream, output stream and counter.
interface gray_code_converter_pipelined_if #(
  parameter int unsigned WIDTH       = 32'd8,
  parameter int unsigned COUNT_WIDTH = 32'd16
);

  logic                   In_Valid;
  logic                   In_Ready;
  logic                   Mode_In;
  logic [WIDTH-1:0]       Code_In;
  logic                   Out_Valid;
  logic                   Out_Ready;
  logic                   Mode_Out;
  logic [WIDTH-1:0]       Code_Out;
  logic [COUNT_WIDTH-1:0] Conversion_Count;

  modport master (
    output In_Valid, Mode_In, Code_In, Out_Ready,
    input  In_Ready, Out_Valid, Mode_Out, Code_Out, Conversion_Count
  );

  modport slave (
    input  In_Valid, Mode_In, Code_In, Out_Ready,
    output In_Ready, Out_Valid, Mode_Out, Code_Out, Conversion_Count
  );

endinterface

// File: rtl/gray_code_converter_pipelined_pipe_stage.sv
// One pipeline register holding {valid, mode, data}; loads on the global advance enable, holds otherwise.
module gray_code_pipe_stage
  import gray_code_pkg::*;
#(
  parameter type stage_t = pipe_stage_t
) (
  input  logic   Clock,
  input  logic   Reset_n,
  input  logic   adv,
  input  stage_t d,
  output stage_t q
);

  // Stage register: cleared by reset, shifts only when the whole pipe advances
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      q <= '0;
    end else if (adv) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/gray_code_converter_pipelined.sv
// Pipelined bidirectional Binary/Gray converter with per-word mode and valid/ready back-pressure.
// Conversion sits in front of stage 1; the remaining LATENCY-1 stages are pure delay.
module gray_code_converter_pipelined
  import gray_code_pkg::*;
#(
  parameter int unsigned WIDTH       = 32'd8,
  parameter int unsigned LATENCY     = 32'd2,
  parameter int unsigned COUNT_WIDTH = 32'd16
) (
  input  logic                            Clock,
  input  logic                            Reset_n,
  gray_code_converter_pipelined_if.slave  bus
);

  typedef struct packed {
    logic             valid;
    conv_mode_e       mode;
    logic [WIDTH-1:0] data;
  } stage_t;

  if (WIDTH < 32'd2 || WIDTH > MAX_WIDTH || LATENCY < 32'd1) begin : g_bad_param
    $error("gray_code_converter_pipelined: unsupported WIDTH/LATENCY");
  end

  conv_mode_e             mode_s;
  logic [MAX_WIDTH-1:0]   code_ext_s;
  stage_t                 in_stage_s;
  stage_t                 pipe_q_s [LATENCY];
  logic                   adv_s;
  logic                   out_hs_s;
  logic [COUNT_WIDTH-1:0] count_r;

  assign mode_s     = conv_mode_e'(bus.Mode_In);
  assign code_ext_s = MAX_WIDTH'(bus.Code_In);

  // Stage-1 input word, converted according to its own mode bit
  always_comb begin
    in_stage_s       = '0;
    in_stage_s.valid = bus.In_Valid;
    in_stage_s.mode  = mode_s;
    case (mode_s)
      MODE_BIN2GRAY: in_stage_s.data = WIDTH'(bin2gray(code_ext_s));
      MODE_GRAY2BIN: in_stage_s.data = WIDTH'(gray2bin(code_ext_s));
      default:       in_stage_s.data = '0;
    endcase
  end

  // Single advance enable for every stage: bubbles are kept, not squeezed out
  assign adv_s    = !pipe_q_s[LATENCY-1].valid || bus.Out_Ready;
  assign out_hs_s = pipe_q_s[LATENCY-1].valid && bus.Out_Ready;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_first
      gray_code_pipe_stage #(.stage_t(stage_t)) u_stage (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .adv     (adv_s),
        .d       (in_stage_s),
        .q       (pipe_q_s[i])
      );
    end else begin : g_delay
      gray_code_pipe_stage #(.stage_t(stage_t)) u_stage (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .adv     (adv_s),
        .d       (pipe_q_s[i-1]),
        .q       (pipe_q_s[i])
      );
    end
  end

  // Completed output handshakes; wraps naturally at 2^COUNT_WIDTH
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_r <= '0;
    end else if (out_hs_s) begin
      count_r <= count_r + COUNT_WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.In_Ready         = adv_s;
  assign bus.Out_Valid        = pipe_q_s[LATENCY-1].valid;
  assign bus.Mode_Out         = pipe_q_s[LATENCY-1].mode;
  assign bus.Code_Out         = pipe_q_s[LATENCY-1].data;
  assign bus.Conversion_Count = count_r;

endmodule

// File: tb/tb_gray_code_converter_pipelined.sv
// Self-checking bench: two converter instances (8-bit/latency 2 and 4-bit/latency 1/4-bit counter)
// checked against a queue-based reference model of the conversion rules.
module tb_gray_code_converter_pipelined;

  localparam int unsigned A_W = 8, A_LAT = 2, A_CW = 16;
  localparam int unsigned B_W = 4, B_LAT = 1, B_CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  gray_code_converter_pipelined_if #(.WIDTH(A_W), .COUNT_WIDTH(A_CW)) a_if ();
  gray_code_converter_pipelined_if #(.WIDTH(B_W), .COUNT_WIDTH(B_CW)) b_if ();

  gray_code_converter_pipelined #(.WIDTH(A_W), .LATENCY(A_LAT), .COUNT_WIDTH(A_CW)) u_dut_a (
    .Clock(clk), .Reset_n(rst_n), .bus(a_if));
  gray_code_converter_pipelined #(.WIDTH(B_W), .LATENCY(B_LAT), .COUNT_WIDTH(B_CW)) u_dut_b (
    .Clock(clk), .Reset_n(rst_n), .bus(b_if));

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference rules: G = B xor (B >> 1); each binary bit is the parity of the Gray bits at and above it
  function automatic logic [31:0] ref_b2g(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] ref_g2b(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // Drive one cycle from posedge+1; acc reports whether the word was accepted on the coming edge
  task automatic step_a(input logic iv, input logic md, input logic [A_W-1:0] cd, input logic ordy,
                        output logic acc);
    a_if.In_Valid = iv; a_if.Mode_In = md; a_if.Code_In = cd; a_if.Out_Ready = ordy;
    @(negedge clk);
    acc = iv && a_if.In_Ready;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic iv, input logic md, input logic [B_W-1:0] cd, input logic ordy,
                        output logic acc);
    b_if.In_Valid = iv; b_if.Mode_In = md; b_if.Code_In = cd; b_if.Out_Ready = ordy;
    @(negedge clk);
    acc = iv && b_if.In_Ready;
    @(posedge clk); #1;
  endtask

  // Scoreboards: expected {mode, code} per accepted word, plus a modelled handshake count
  logic [A_W:0]    sb_a_q [$];
  logic [B_W:0]    sb_b_q [$];
  logic [A_CW-1:0] cnt_a_m = '0;
  logic [B_CW-1:0] cnt_b_m = '0;
  logic            stall_a = 1'b0, stall_b = 1'b0;
  logic [A_W:0]    held_a = '0, exp_a;
  logic [B_W:0]    held_b = '0, exp_b;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb_a_q.delete(); cnt_a_m = '0; stall_a = 1'b0;
    end else begin
      check_value("a_count", 64'(a_if.Conversion_Count), 64'(cnt_a_m));
      check_value("a_in_ready", 64'(a_if.In_Ready), 64'(!a_if.Out_Valid || a_if.Out_Ready));
      if (stall_a) begin
        check_value("a_stall_valid", 64'(a_if.Out_Valid), 64'd1);
        check_value("a_stall_hold", 64'({a_if.Mode_Out, a_if.Code_Out}), 64'(held_a));
      end
      stall_a = a_if.Out_Valid && !a_if.Out_Ready;
      held_a  = {a_if.Mode_Out, a_if.Code_Out};
      if (a_if.Out_Valid && a_if.Out_Ready) begin
        check_value("a_out_expected", 64'(sb_a_q.size() != 0), 64'd1);
        if (sb_a_q.size() != 0) begin
          exp_a = sb_a_q.pop_front();
          check_value("a_out_word", 64'({a_if.Mode_Out, a_if.Code_Out}), 64'(exp_a));
        end
        cnt_a_m = cnt_a_m + A_CW'(1);
      end
      if (a_if.In_Valid && a_if.In_Ready)
        sb_a_q.push_back({a_if.Mode_In, A_W'(a_if.Mode_In ? ref_g2b(32'(a_if.Code_In))
                                                           : ref_b2g(32'(a_if.Code_In)))});
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb_b_q.delete(); cnt_b_m = '0; stall_b = 1'b0;
    end else begin
      check_value("b_count", 64'(b_if.Conversion_Count), 64'(cnt_b_m));
      check_value("b_in_ready", 64'(b_if.In_Ready), 64'(!b_if.Out_Valid || b_if.Out_Ready));
      if (stall_b) begin
        check_value("b_stall_valid", 64'(b_if.Out_Valid), 64'd1);
        check_value("b_stall_hold", 64'({b_if.Mode_Out, b_if.Code_Out}), 64'(held_b));
      end
      stall_b = b_if.Out_Valid && !b_if.Out_Ready;
      held_b  = {b_if.Mode_Out, b_if.Code_Out};
      if (b_if.Out_Valid && b_if.Out_Ready) begin
        check_value("b_out_expected", 64'(sb_b_q.size() != 0), 64'd1);
        if (sb_b_q.size() != 0) begin
          exp_b = sb_b_q.pop_front();
          check_value("b_out_word", 64'({b_if.Mode_Out, b_if.Code_Out}), 64'(exp_b));
        end
        cnt_b_m = cnt_b_m + B_CW'(1);
      end
      if (b_if.In_Valid && b_if.In_Ready)
        sb_b_q.push_back({b_if.Mode_In, B_W'(b_if.Mode_In ? ref_g2b(32'(b_if.Code_In))
                                                           : ref_b2g(32'(b_if.Code_In)))});
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_value("rst_a_valid", 64'(a_if.Out_Valid), 64'd0);
    check_value("rst_a_code", 64'(a_if.Code_Out), 64'd0);
    check_value("rst_a_mode", 64'(a_if.Mode_Out), 64'd0);
    check_value("rst_a_count", 64'(a_if.Conversion_Count), 64'd0);
    check_value("rst_b_valid", 64'(b_if.Out_Valid), 64'd0);
    check_value("rst_b_code", 64'(b_if.Code_Out), 64'd0);
    check_value("rst_b_count", 64'(b_if.Conversion_Count), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_value("rst_a_in_ready", 64'(a_if.In_Ready), 64'd1);
    check_value("rst_b_in_ready", 64'(b_if.In_Ready), 64'd1);
  endtask

  task automatic drain_a();
    logic acc;
    repeat (A_LAT + 2) step_a(1'b0, 1'b0, '0, 1'b1, acc);
    check_value("a_drained", 64'(sb_a_q.size()), 64'd0);
  endtask

  task automatic drain_b();
    logic acc;
    repeat (B_LAT + 2) step_b(1'b0, 1'b0, '0, 1'b1, acc);
    check_value("b_drained", 64'(sb_b_q.size()), 64'd0);
  endtask

  // Single word through an empty pipe: measure edges from accept to Out_Valid
  task automatic latency_a(input string tag, input logic md, input logic [A_W-1:0] cd,
                           input logic [A_W-1:0] exp_code);
    logic acc;
    int unsigned lat;
    step_a(1'b1, md, cd, 1'b1, acc);
    check_value({tag, "_acc"}, 64'(acc), 64'd1);
    lat = 1;
    while (!a_if.Out_Valid && lat < 16) begin
      step_a(1'b0, 1'b0, '0, 1'b0, acc);
      lat++;
    end
    check_value({tag, "_latency"}, 64'(lat), 64'(A_LAT));
    check_value({tag, "_code"}, 64'(a_if.Code_Out), 64'(exp_code));
    check_value({tag, "_mode"}, 64'(a_if.Mode_Out), 64'(md));
    drain_a();
  endtask

  initial begin
    logic acc, pend;
    logic [A_W-1:0] w;
    logic [A_W:0]   held;
    logic [A_W-1:0] gq [$];
    logic [A_W-1:0] rq [$];

    a_if.In_Valid = 1'b0; a_if.Mode_In = 1'b0; a_if.Code_In = '0; a_if.Out_Ready = 1'b0;
    b_if.In_Valid = 1'b0; b_if.Mode_In = 1'b0; b_if.Code_In = '0; b_if.Out_Ready = 1'b0;
    #2;
    apply_reset();

    // 4-bit, latency 1: word is visible right after its accept edge
    step_b(1'b1, 1'b0, 4'b1011, 1'b1, acc);
    check_value("b_b2g_valid", 64'(b_if.Out_Valid), 64'd1);
    check_value("b_b2g_1011", 64'(b_if.Code_Out), 64'(4'b1110));
    check_value("b_b2g_mode", 64'(b_if.Mode_Out), 64'd0);
    step_b(1'b1, 1'b1, 4'b1110, 1'b1, acc);
    check_value("b_g2b_valid", 64'(b_if.Out_Valid), 64'd1);
    check_value("b_g2b_1110", 64'(b_if.Code_Out), 64'(4'b1011));
    check_value("b_g2b_mode", 64'(b_if.Mode_Out), 64'd1);
    drain_b();

    latency_a("a_b2g_ff", 1'b0, 8'hFF, 8'h80);
    latency_a("a_g2b_80", 1'b1, 8'h80, 8'hFF);

    // Exhaustive round trip at full throughput
    for (int i = 0; i < 256 + A_LAT - 1; i++) begin
      step_a(i < 256, 1'b0, 8'(i), 1'b1, acc);
      if (a_if.Out_Valid) gq.push_back(a_if.Code_Out);
    end
    check_value("a_b2g_throughput", 64'(gq.size()), 64'd256);
    for (int i = 0; i < 256 + A_LAT - 1; i++) begin
      step_a(i < gq.size(), 1'b1, (i < gq.size()) ? gq[i] : 8'h00, 1'b1, acc);
      if (a_if.Out_Valid) rq.push_back(a_if.Code_Out);
    end
    check_value("a_g2b_throughput", 64'(rq.size()), 64'd256);
    for (int i = 0; i < rq.size(); i++) check_value("a_round_trip", 64'(rq[i]), 64'(i));
    drain_a();

    // Back-pressure with a full pipe
    pend = 1'b0;
    w = '0;
    for (int c = 0; c < 3; c++) begin
      if (!pend) w = 8'($urandom);
      step_a(1'b1, 1'b0, w, 1'b0, acc);
      pend = !acc;
    end
    check_value("a_bp_full", 64'(pend), 64'd1);
    held = {a_if.Mode_Out, a_if.Code_Out};
    for (int c = 0; c < 5; c++) begin
      step_a(1'b1, 1'b0, w, 1'b0, acc);
      check_value("a_bp_in_ready", 64'(a_if.In_Ready), 64'd0);
      check_value("a_bp_no_accept", 64'(acc), 64'd0);
      check_value("a_bp_held", 64'({a_if.Mode_Out, a_if.Code_Out}), 64'(held));
    end
    for (int c = 0; c < 10 && pend; c++) begin
      step_a(1'b1, 1'b0, w, 1'b1, acc);
      pend = !acc;
    end
    check_value("a_bp_release", 64'(pend), 64'd0);
    drain_a();

    // Random traffic, mode alternating per word, random consumer stalls
    fork
      begin
        logic ra_acc, ra_pend, ra_iv, ra_md;
        logic [A_W-1:0] ra_w;
        int unsigned ra_idx;
        ra_pend = 1'b0; ra_iv = 1'b0; ra_md = 1'b0; ra_w = '0; ra_idx = 0;
        for (int c = 0; c < 400; c++) begin
          if (!ra_pend) begin
            ra_iv = ($urandom_range(0, 3) != 0);
            if (ra_iv) begin
              ra_w = 8'($urandom); ra_md = ra_idx[0]; ra_idx++;
            end
          end
          step_a(ra_iv, ra_md, ra_w, $urandom_range(0, 2) != 0, ra_acc);
          ra_pend = ra_iv && !ra_acc;
        end
        for (int c = 0; c < 10 && ra_pend; c++) begin
          step_a(1'b1, ra_md, ra_w, 1'b1, ra_acc);
          ra_pend = !ra_acc;
        end
      end
      begin
        logic rb_acc, rb_pend, rb_iv, rb_md;
        logic [B_W-1:0] rb_w;
        int unsigned rb_idx;
        rb_pend = 1'b0; rb_iv = 1'b0; rb_md = 1'b0; rb_w = '0; rb_idx = 0;
        for (int c = 0; c < 400; c++) begin
          if (!rb_pend) begin
            rb_iv = ($urandom_range(0, 3) != 0);
            if (rb_iv) begin
              rb_w = 4'($urandom); rb_md = rb_idx[0]; rb_idx++;
            end
          end
          step_b(rb_iv, rb_md, rb_w, $urandom_range(0, 1) != 0, rb_acc);
          rb_pend = rb_iv && !rb_acc;
        end
        for (int c = 0; c < 10 && rb_pend; c++) begin
          step_b(1'b1, rb_md, rb_w, 1'b1, rb_acc);
          rb_pend = !rb_acc;
        end
      end
    join
    drain_a();
    drain_b();

    // Reset with two words in flight: nothing stale may emerge afterwards
    step_a(1'b1, 1'b0, 8'h5A, 1'b0, acc);
    step_a(1'b1, 1'b1, 8'hC3, 1'b0, acc);
    check_value("a_mid_inflight", 64'(a_if.Out_Valid), 64'd1);
    a_if.In_Valid = 1'b0;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      step_a(1'b0, 1'b0, '0, 1'b1, acc);
      check_value("a_no_stale", 64'(a_if.Out_Valid), 64'd0);
    end

    // 17 handshakes on a 4-bit counter wrap to 1
    for (int c = 0; c < 17; c++) step_b(1'b1, 1'(c), 4'($urandom), 1'b1, acc);
    drain_b();
    check_value("b_count_wrap", 64'(b_if.Conversion_Count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gray_code_converter_pipelined.md
Name: gray_code_converter_pipelined

Overview:
Parametrised, pipelined, bidirectional Binary/Gray code converter with a valid/ready stream handshake.
Each accepted word carries its own mode bit: binary-to-Gray or Gray-to-binary.
It is the streaming, width-generic successor to the fixed 4-bit combinational converter.
It sits between producer and consumer stages (counters, async-FIFO pointer paths) that need registered, back-pressurable code conversion.

Parameters:
WIDTH, 8, data word width in bits (>=2).
LATENCY, 2, register stages from input to output (>=1); fixed cycles from accept to Out_Valid with no stall.
COUNT_WIDTH, 16, width of the completed-conversion counter.

Ports:
Clock  input  1  rising-edge clock.
Reset_n  input  1  asynchronous, active-low reset.
In_Valid  input  1  input word present.
In_Ready  output  1  converter can accept this cycle.
Mode_In  input  1  0 = binary-to-Gray, 1 = Gray-to-binary.
Code_In  input  WIDTH  word to convert.
Out_Valid  output  1  converted word present.
Out_Ready  input  1  consumer accepts this cycle.
Mode_Out  output  1  mode the word was converted with.
Code_Out  output  WIDTH  converted word.
Conversion_Count  output  COUNT_WIDTH  number of output handshakes completed.

Behaviour:
- Reset (Reset_n low, asynchronous): every stage valid bit = 0; Out_Valid = 0; Code_Out = 0; Mode_Out = 0; Conversion_Count = 0. In_Ready = 1 once reset deasserts.
- Accept: on a rising edge with In_Valid && In_Ready. Output handshake: on a rising edge with Out_Valid && Out_Ready.
- Pipeline: LATENCY stages, each holding {valid, mode, data}.
  - Global advance enable: Adv = !Out_Valid || Out_Ready.
  - In_Ready = Adv (combinational; no path from In_Valid).
- When Adv = 1, every stage loads from the stage before it. Stage 1 loads {In_Valid, Mode_In, converted Code_In}.
- When Adv = 0, all stages hold. Bubbles are not collapsed.
- Conversion is done combinationally ahead of stage 1; later stages only delay.
  - Binary-to-Gray: G = B ^ (B >> 1).
  - Gray-to-binary: B[WIDTH-1] = G[WIDTH-1]; B[i] = B[i+1] ^ G[i] for i = WIDTH-2 down to 0.
  - Mode 1 is a prefix-XOR chain; it must meet timing at WIDTH = 32.
- Latency: a word accepted at edge N appears with Out_Valid = 1 after edge N+LATENCY-1, provided Adv stays 1. With LATENCY = 1 the output registers are stage 1.
- Stall: while Out_Valid && !Out_Ready, Code_Out and Mode_Out are stable and In_Ready = 0. Nothing is dropped or duplicated.
- Throughput: one word per cycle when Out_Ready is held at 1.
- Simultaneous events:
  - Output handshake and input accept on the same edge are legal; the pipeline shifts by one.
  - In_Valid with In_Ready = 0 is ignored. The producer must hold the word.
- Data stages hold their value (don't-care) when their valid bit = 0. Code_Out is only meaningful while Out_Valid = 1.
- Conversion_Count increments by 1 on each output handshake and wraps from 2^COUNT_WIDTH-1 to 0.
- Reset mid-stream: all in-flight words are discarded, outputs return to reset values immediately, and the count clears.

Decomposition:
- Shared package gray_code_pkg:
  - typedef conv_mode_e {MODE_BIN2GRAY = 1'b0, MODE_GRAY2BIN = 1'b1};
  - parametrised functions bin2gray(), gray2bin();
  - the stage struct type {valid, mode, data}.
- One natural sub-module: gray_code_pipe_stage, a single registered stage with valid bit, hold-on-stall and async reset, generated LATENCY times.

Test Plan:
- Reset: assert Reset_n = 0 mid-stream with 2 words in flight -> Out_Valid = 0 and Conversion_Count = 0 immediately; after release, In_Ready = 1 and no stale word emerges.
- WIDTH = 4, Mode 0, Code_In = 4'b1011 -> Code_Out = 4'b1110 exactly LATENCY edges later. Mode 1, Code_In = 4'b1110 -> Code_Out = 4'b1011.
- WIDTH = 8, streaming: Mode 0 with 8'hFF -> 8'h80; Mode 1 with 8'h80 -> 8'hFF. Then an exhaustive 0..255 round-trip (bin2gray then gray2bin) with Out_Ready = 1 -> identity, one output per cycle.
- Back-pressure: Out_Ready = 0 for 5 cycles with the pipeline full -> In_Ready = 0 and Code_Out/Mode_Out stable. Release -> words emerge in order with no loss or duplication.
- Mixed modes interleaved, alternating per cycle, with random Out_Ready -> Mode_Out tags each word correctly; Conversion_Count equals the handshake count.
- COUNT_WIDTH = 4: 17 output handshakes -> Conversion_Count = 1 (wrap after 15).
